// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline control slice.
package arm_pkg;

    localparam int REG_IDX_W = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall control bus between the pipeline datapath (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if
    import arm_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic [REG_IDX_W-1:0] src1;
    logic [REG_IDX_W-1:0] src2;
    logic                 src1_valid;
    logic                 two_src;
    logic                 exe_wb_en;
    logic [REG_IDX_W-1:0] exe_dest;
    logic                 exe_mem_read_en;
    logic                 mem_wb_en;
    logic [REG_IDX_W-1:0] mem_dest;
    logic                 mem_access;
    logic                 branch_taken;

    logic                 freeze_front;
    logic                 freeze_all;
    logic                 flush;
    logic                 bubble;
    logic [1:0]           fwd_sel1;
    logic [1:0]           fwd_sel2;
    logic                 mem_busy;
    logic [CNT_W-1:0]     stall_cycles;

    modport master (
        output src1, src2, src1_valid, two_src, exe_wb_en, exe_dest, exe_mem_read_en,
               mem_wb_en, mem_dest, mem_access, branch_taken,
        input  freeze_front, freeze_all, flush, bubble, fwd_sel1, fwd_sel2, mem_busy,
               stall_cycles
    );

    modport slave (
        input  src1, src2, src1_valid, two_src, exe_wb_en, exe_dest, exe_mem_read_en,
               mem_wb_en, mem_dest, mem_access, branch_taken,
        output freeze_front, freeze_all, flush, bubble, fwd_sel1, fwd_sel2, mem_busy,
               stall_cycles
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Combinational RAW hazard detection and forwarding selects.
// Forwarding is enabled by defining PIPE_CTRL_FORWARDING_EN.
module hazard_unit
    import arm_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 src1_valid,
    input  logic                 two_src,
    input  logic                 exe_wb_en,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_mem_read_en,
    input  logic                 mem_wb_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    output logic                 hz,
    output fwd_sel_e             fwd_sel1,
    output fwd_sel_e             fwd_sel2
);

    logic s1_exe, s1_mem, s2_exe, s2_mem;

    assign s1_exe = src1_valid & exe_wb_en & (exe_dest == src1);
    assign s1_mem = src1_valid & mem_wb_en & (mem_dest == src1);
    assign s2_exe = two_src    & exe_wb_en & (exe_dest == src2);
    assign s2_mem = two_src    & mem_wb_en & (mem_dest == src2);

`ifdef PIPE_CTRL_FORWARDING_EN
    // Only a load in EXE cannot be bypassed: its data exists one cycle too late.
    assign hz       = exe_mem_read_en & (s1_exe | s2_exe);
    assign fwd_sel1 = s1_exe ? FWD_EXE : (s1_mem ? FWD_WB : FWD_RF);
    assign fwd_sel2 = s2_exe ? FWD_EXE : (s2_mem ? FWD_WB : FWD_RF);
`else
    logic unused_load;

    assign unused_load = exe_mem_read_en;
    assign hz          = s1_exe | s1_mem | s2_exe | s2_mem;
    assign fwd_sel1    = FWD_RF;
    assign fwd_sel2    = FWD_RF;
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall sequencer: memory wait-state FSM, control priority and stall counter.
// Optional forwarding via PIPE_CTRL_FORWARDING_EN (handled in hazard_unit).
module pipeline_ctrl
    import arm_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    localparam int  WCNT_W       = (MEM_WAIT_CYCLES > 2) ? $clog2(MEM_WAIT_CYCLES) : 1;
    localparam bit  MEM_STALL_EN = (MEM_WAIT_CYCLES > 0);
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        WCNT_W'((MEM_WAIT_CYCLES > 0) ? MEM_WAIT_CYCLES - 1 : 0);

    mem_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q;
    logic              hz;
    logic              freeze_all;
    logic              freeze_front;
    fwd_sel_e          fwd1, fwd2;

    hazard_unit u_hazard (
        .src1            (bus.src1),
        .src2            (bus.src2),
        .src1_valid      (bus.src1_valid),
        .two_src         (bus.two_src),
        .exe_wb_en       (bus.exe_wb_en),
        .exe_dest        (bus.exe_dest),
        .exe_mem_read_en (bus.exe_mem_read_en),
        .mem_wb_en       (bus.mem_wb_en),
        .mem_dest        (bus.mem_dest),
        .hz              (hz),
        .fwd_sel1        (fwd1),
        .fwd_sel2        (fwd2)
    );

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            RUN: begin
                if (MEM_STALL_EN && bus.mem_access) begin
                    if (MEM_WAIT_CYCLES == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                // The counter reaches zero on the edge that enters DONE (the release cycle).
                wait_d = wait_q - 1'b1;
                if (wait_q == WCNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign freeze_all   = ((state_q == RUN) && bus.mem_access && MEM_STALL_EN) ||
                          (state_q == WAIT);
    // A frozen branch waits for the release cycle; a taken branch discards the ID hazard.
    assign freeze_front = !freeze_all && !bus.branch_taken && hz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((freeze_front || freeze_all) && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.freeze_all   = freeze_all;
    assign bus.freeze_front = freeze_front;
    assign bus.bubble       = freeze_front;
    assign bus.flush        = !freeze_all && bus.branch_taken;
    assign bus.fwd_sel1     = fwd1;
    assign bus.fwd_sel2     = fwd2;
    assign bus.mem_busy     = (state_q != RUN);
    assign bus.stall_cycles = stall_q;

endmodule
